// File: rtl/mm_bram_responder.sv
// Dual-ported front end for one shared single-port 32-bit word array.
// The core (BRAM-style) port always wins; host requests fill idle cycles.
module mm_bram_responder #(
  parameter int DEPTH        = 64,
  parameter int READ_LATENCY = 1
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     BRAM_en_i,
  input  logic [3:0]               BRAM_we_i,
  input  logic [31:0]              BRAM_addr_i,
  input  logic [31:0]              BRAM_din_i,
  output logic [31:0]              BRAM_dout_o,
  input  logic                     host_valid_i,
  output logic                     host_ready_o,
  input  logic                     host_we_i,
  input  logic [$clog2(DEPTH)-1:0] host_addr_i,
  input  logic [31:0]              host_wdata_i,
  output logic                     host_rvalid_o,
  output logic [31:0]              host_rdata_o,
  output logic                     err_o,
  input  logic                     err_clr_i
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [31:0]   rd_word_reg;

  logic          core_legal;
  logic          host_fire;
  logic          acc_en;
  logic [AW-1:0] acc_addr;
  logic [3:0]    acc_we;
  logic [31:0]   acc_wdata;

  logic          core_v1_reg;
  logic          host_v1_reg;
  logic          ill1_reg;
  logic          err_reg;
  logic [31:0]   core_res;
  logic [31:0]   core_hold_reg;
  logic [31:0]   host_hold_reg;

  // Upper address bits beyond the array must be zero, and the access word-aligned.
  assign core_legal   = (BRAM_addr_i[1:0] == 2'b00) && (BRAM_addr_i[31:AW+2] == '0);
  assign host_fire    = host_valid_i & ~BRAM_en_i;
  assign host_ready_o = host_fire;

  always_comb begin
    acc_en    = BRAM_en_i | host_valid_i;
    acc_addr  = host_addr_i;
    acc_we    = {4{host_we_i}};
    acc_wdata = host_wdata_i;
    if (BRAM_en_i) begin
      acc_addr  = BRAM_addr_i[AW+1:2];
      acc_we    = core_legal ? BRAM_we_i : 4'b0000;
      acc_wdata = BRAM_din_i;
    end
  end

  // Read-first array port: the read register captures the word before any byte update.
  always_ff @(posedge clock_i) begin
    if (acc_en) begin
      rd_word_reg <= mem[acc_addr];
      for (int k = 0; k < 4; k++) begin
        if (acc_we[k]) begin
          mem[acc_addr][k*8 +: 8] <= acc_wdata[k*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      core_v1_reg <= 1'b0;
      host_v1_reg <= 1'b0;
      ill1_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      core_v1_reg <= BRAM_en_i;
      host_v1_reg <= host_fire & ~host_we_i;
      ill1_reg    <= BRAM_en_i & ~core_legal;
      if (BRAM_en_i && !core_legal) begin
        err_reg <= 1'b1;
      end else if (err_clr_i) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign core_res = ill1_reg ? 32'h0 : rd_word_reg;
  assign err_o    = err_reg;

  // Hold registers keep the last result; at latency 2 they are also the output stage.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      core_hold_reg <= 32'h0;
      host_hold_reg <= 32'h0;
    end else begin
      if (core_v1_reg) begin
        core_hold_reg <= core_res;
      end
      if (host_v1_reg) begin
        host_hold_reg <= rd_word_reg;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic host_v2_reg;
      always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
          host_v2_reg <= 1'b0;
        end else begin
          host_v2_reg <= host_v1_reg;
        end
      end
      assign BRAM_dout_o   = core_hold_reg;
      assign host_rdata_o  = host_hold_reg;
      assign host_rvalid_o = host_v2_reg;
    end else begin : g_lat1
      assign BRAM_dout_o   = core_v1_reg ? core_res : core_hold_reg;
      assign host_rdata_o  = host_v1_reg ? rd_word_reg : host_hold_reg;
      assign host_rvalid_o = host_v1_reg;
    end
  endgenerate

endmodule

// File: doc/mm_bram_responder.md
MM_BRAM_RESPONDER -- requirements
Module: mm_bram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit words stored (power of two, 16..1024).
REQ-002 SHALL have parameter READ_LATENCY, default 1, meaning cycles from accepted read to valid data (legal values 1 or 2).
REQ-003 SHALL have port clock_i  in  1  single clock for all logic.
REQ-004 SHALL have port reset_i  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port BRAM_en_i  in  1  core-side access enable.
REQ-006 SHALL have port BRAM_we_i  in  4  core-side byte write enables.
REQ-007 SHALL have port BRAM_addr_i  in  32  core-side byte address.
REQ-008 SHALL have port BRAM_din_i  in  32  core-side write data.
REQ-009 SHALL have port BRAM_dout_o  out  32  core-side read data.
REQ-010 SHALL have port host_valid_i  in  1  host request valid.
REQ-011 SHALL have port host_ready_o  out  1  host request accepted this cycle.
REQ-012 SHALL have port host_we_i  in  1  host request is a full-word write.
REQ-013 SHALL have port host_addr_i  in  $clog2(DEPTH)  host word address.
REQ-014 SHALL have port host_wdata_i  in  32  host write data.
REQ-015 SHALL have port host_rvalid_o  out  1  one-cycle pulse marking host_rdata_o valid.
REQ-016 SHALL have port host_rdata_o  out  32  host read data.
REQ-017 SHALL have port err_o  out  1  sticky core-side address error flag.
REQ-018 SHALL have port err_clr_i  in  1  clears err_o.

Function
REQ-019 SHALL decode core word index as BRAM_addr_i[31:2].
REQ-020 SHALL, when BRAM_en_i=1 and address legal, write byte k of BRAM_din_i into byte k of the word for each BRAM_we_i[k]=1, leaving other bytes unchanged.
REQ-021 SHALL, when BRAM_en_i=1, present the pre-write word contents (read-first) on BRAM_dout_o exactly READ_LATENCY cycles later.
REQ-022 SHALL hold BRAM_dout_o at its last value while no core read result is due.
REQ-023 SHALL treat a core access as illegal when BRAM_addr_i[1:0]!=0 or word index >= DEPTH: writes ignored, read result 0, err_o set on the following cycle.
REQ-024 SHALL keep err_o high until err_clr_i=1; err_clr_i and a new error in the same cycle leave err_o=1.
REQ-025 SHALL give the core port absolute priority: host_ready_o = host_valid_i AND NOT BRAM_en_i, combinationally.
REQ-026 SHALL complete a host transfer only when host_valid_i=1 and host_ready_o=1; host SHALL hold request fields stable until accepted.
REQ-027 SHALL write host_wdata_i to the full word for accepted host writes.
REQ-028 SHALL pulse host_rvalid_o for one cycle exactly READ_LATENCY cycles after an accepted host read, with host_rdata_o holding that data until the next pulse.
REQ-029 SHALL generate no host_rvalid_o pulse for host writes.
REQ-030 SHALL sustain one accepted access per cycle on the shared array, with back-to-back reads fully pipelined at both latencies.
REQ-031 SHALL, with READ_LATENCY=2, add one output register stage after the array read register on both ports.

Reset
REQ-032 SHALL, while reset_i=0, force BRAM_dout_o=0, host_rdata_o=0, host_rvalid_o=0, err_o=0 and clear all in-flight read pipeline valids.
REQ-033 SHALL not clear array contents on reset.
REQ-034 SHALL discard reads in flight when reset asserts mid-operation; no host_rvalid_o pulse after reset release for pre-reset requests.
REQ-035 SHALL accept its first access on the first rising edge after reset_i deasserts.

Verification
REQ-036 Host writes 0x0001ABCD to word 3, then host read of word 3 -> host_rvalid_o pulses after READ_LATENCY cycles with host_rdata_o=0x0001ABCD.
REQ-037 Word 5=0xFFFFFFFF; core en=1, we=4'b0101, addr=0x14, din=0x00000000 -> later core read of 0x14 returns 0xFF00FF00.
REQ-038 Core en=1 and host_valid_i=1 in cycles 0-2, core idle cycle 3 -> host_ready_o=0 cycles 0-2, 1 in cycle 3; exactly one host transfer.
REQ-039 Core read addr=0x06, then addr=DEPTH*4 -> both return 0, err_o=1 from next cycle, stays 1 until err_clr_i pulse, then 0.
REQ-040 Core write to word 7 with read-first: word 7=0x11, en=1, we=4'hF, din=0x22 -> BRAM_dout_o=0x11 after READ_LATENCY, subsequent read returns 0x22.
REQ-041 Host read accepted, reset_i=0 one cycle later -> outputs 0, no host_rvalid_o pulse after release, previously written words unchanged.
